// File: rtl/axi_chn_tmout_mon_if.sv
// Per-channel valid/ready bundle observed by the channel timeout monitor.
interface axi_chn_tmout_mon_if #(
  parameter int unsigned CHN_NUM = 5
);
  logic [CHN_NUM-1:0] vld_in;
  logic [CHN_NUM-1:0] ready_in;

  modport master (output vld_in, output ready_in);
  modport slave  (input  vld_in, input  ready_in);
endinterface

// File: rtl/axi_chn_tmout_mon.sv
// Per-channel valid/ready stall watchdog: flags channels stalled for longer than a
// configurable number of microseconds, with sticky status, irq and an event counter.
module axi_chn_tmout_mon #(
  parameter int unsigned CHN_NUM       = 5,
  parameter int unsigned TIMER_1US_CFG = 200,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                      clks,
  input  logic                      reset,
  axi_chn_tmout_mon_if.slave        chn,
  input  logic [CNT_W-1:0]          reg_tmout_us_cfg,
  input  logic                      reg_tmout_en,
  input  logic [CHN_NUM-1:0]        reg_chn_mask,
  input  logic                      reg_sts_clr,
  output logic [CHN_NUM-1:0]        time_out,
  output logic [CHN_NUM-1:0]        tmout_sts,
  output logic                      tmout_irq,
  output logic [15:0]               tmout_evt_cnt
);

  localparam int unsigned PW = (TIMER_1US_CFG > 1) ? $clog2(TIMER_1US_CFG) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_1US_CFG - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StExpire = 2'd2;

  logic [1:0]         state_q   [CHN_NUM];
  logic [1:0]         state_d   [CHN_NUM];
  logic [PW-1:0]      presc_q   [CHN_NUM];
  logic [PW-1:0]      presc_d   [CHN_NUM];
  logic [PW-1:0]      presc_inc [CHN_NUM];
  logic [CNT_W-1:0]   us_q      [CHN_NUM];
  logic [CNT_W-1:0]   us_d      [CHN_NUM];
  logic [CNT_W-1:0]   us_inc    [CHN_NUM];

  logic [CHN_NUM-1:0] stall;
  logic [CHN_NUM-1:0] active;
  logic [CHN_NUM-1:0] time_out_q, time_out_d;
  logic [CHN_NUM-1:0] sts_q, sts_d;
  logic               irq_q;
  logic [15:0]        evt_q, evt_d;
  logic [16:0]        pop;
  logic [16:0]        evt_sum;

  assign stall  = chn.vld_in & ~chn.ready_in;
  assign active = {CHN_NUM{reg_tmout_en & (reg_tmout_us_cfg != '0)}} & ~reg_chn_mask;

  always_comb begin
    time_out_d = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      presc_inc[i] = (presc_q[i] == PRESC_MAX) ? '0 : presc_q[i] + PW'(1);
      // Microsecond count saturates rather than wrapping back below cfg.
      us_inc[i]    = (presc_q[i] == PRESC_MAX && us_q[i] != '1) ? us_q[i] + CNT_W'(1)
                                                                 : us_q[i];
      state_d[i]   = state_q[i];
      presc_d[i]   = presc_q[i];
      us_d[i]      = us_q[i];
      if (!active[i] || !stall[i]) begin
        state_d[i] = StIdle;
        presc_d[i] = '0;
        us_d[i]    = '0;
      end else begin
        case (state_q[i])
          StIdle: begin
            state_d[i] = StWait;
            presc_d[i] = PW'(1);
            us_d[i]    = '0;
          end
          StWait: begin
            presc_d[i] = presc_inc[i];
            us_d[i]    = us_inc[i];
            if (us_inc[i] >= reg_tmout_us_cfg) begin
              state_d[i]    = StExpire;
              time_out_d[i] = 1'b1;
            end
          end
          StExpire: ;
          default: begin
            state_d[i] = StIdle;
            presc_d[i] = '0;
            us_d[i]    = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      pop = pop + 17'(time_out_q[i]);
    end
    evt_sum = {1'b0, evt_q} + pop;
    if (reg_sts_clr) begin
      evt_d = pop[15:0];
    end else begin
      evt_d = evt_sum[16] ? 16'hFFFF : evt_sum[15:0];
    end
    // A pulse arriving with the clear still lands in the status.
    sts_d = (reg_sts_clr ? '0 : sts_q) | time_out_q;
  end

  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHN_NUM; i++) begin
        state_q[i] <= StIdle;
        presc_q[i] <= '0;
        us_q[i]    <= '0;
      end
      time_out_q <= '0;
      sts_q      <= '0;
      irq_q      <= 1'b0;
      evt_q      <= '0;
    end else begin
      for (int i = 0; i < CHN_NUM; i++) begin
        state_q[i] <= state_d[i];
        presc_q[i] <= presc_d[i];
        us_q[i]    <= us_d[i];
      end
      time_out_q <= time_out_d;
      sts_q      <= sts_d;
      irq_q      <= |sts_q;
      evt_q      <= evt_d;
    end
  end

  assign time_out      = time_out_q;
  assign tmout_sts     = sts_q;
  assign tmout_irq     = irq_q;
  assign tmout_evt_cnt = evt_q;

endmodule

// File: doc/axi_chn_tmout_mon.md
AXI_CHN_TMOUT_MON -- requirements
Module: axi_chn_tmout_mon

Interface
REQ-001 Parameter CHN_NUM, default 5, sets the number of monitored valid/ready channels (AW, W, B, AR, R order, bit 0 = AW).
REQ-002 Parameter TIMER_1US_CFG, default 200, sets clks cycles per microsecond tick (legal range 2..4095).
REQ-003 Parameter CNT_W, default 16, sets the width of the microsecond counter and timeout config.
REQ-004 clks  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vld_in  input  CHN_NUM  per-channel valid.
REQ-007 ready_in  input  CHN_NUM  per-channel ready.
REQ-008 reg_tmout_us_cfg  input  CNT_W  timeout in microseconds, shared by all channels; 0 = timing disabled.
REQ-009 reg_tmout_en  input  1  global monitor enable.
REQ-010 reg_chn_mask  input  CHN_NUM  1 = channel ignored.
REQ-011 reg_sts_clr  input  1  single-cycle pulse clearing sticky status and event counter.
REQ-012 time_out  output  CHN_NUM  registered one-cycle expiry pulse per channel.
REQ-013 tmout_sts  output  CHN_NUM  registered sticky expiry status.
REQ-014 tmout_irq  output  1  registered OR of tmout_sts.
REQ-015 tmout_evt_cnt  output  16  registered saturating count of expiry events.

Function
REQ-016 Stall on channel i SHALL be vld_in[i]=1 and ready_in[i]=0; each channel SHALL own a prescaler (width clog2(TIMER_1US_CFG)) and a CNT_W-bit microsecond counter.
REQ-017 Per-channel FSM states SHALL be IDLE, WAIT, EXPIRE.
REQ-018 IDLE -> WAIT on a sampled stall while enabled, unmasked and cfg != 0; that stall cycle counts as stall cycle 1 (prescaler loads 1).
REQ-019 In WAIT, every sampled stall cycle SHALL increment the prescaler; on reaching TIMER_1US_CFG it wraps to 0 and the microsecond counter increments.
REQ-020 WAIT -> EXPIRE at the edge sampling stall cycle number cfg*TIMER_1US_CFG (microsecond counter >= cfg after update); time_out[i]=1 for exactly the following cycle.
REQ-021 Comparison SHALL be >= against the live cfg: lowering cfg below the accumulated count mid-WAIT expires on the next sampled stall cycle.
REQ-022 EXPIRE SHALL hold (no further pulses) until the stall ends; then -> IDLE.
REQ-023 From WAIT or EXPIRE, any cycle with vld_in[i]=0 or ready_in[i]=1 SHALL return to IDLE and zero both counters; a stall in that same cycle is not counted.
REQ-024 reg_tmout_en=0, mask[i]=1 or cfg=0 SHALL force channel i to IDLE with counters zeroed; tmout_sts and tmout_evt_cnt hold.
REQ-025 Microsecond counter SHALL saturate at all-ones, never wrap.
REQ-026 tmout_sts[i] SHALL set on every time_out[i] pulse and clear only on reg_sts_clr; same-cycle set and clear -> set wins.
REQ-027 tmout_evt_cnt SHALL add popcount(time_out) each cycle, saturating at 16'hFFFF; on reg_sts_clr it loads popcount(time_out) of that cycle.
REQ-028 tmout_irq SHALL equal the OR of tmout_sts, one register stage later.

Reset
REQ-029 On reset all FSMs IDLE, all counters 0, time_out=0, tmout_sts=0, tmout_irq=0, tmout_evt_cnt=0.
REQ-030 Reset asserted mid-WAIT SHALL abort timing with no pulse; after release the stall is treated as new.

Verification (TIMER_1US_CFG=4, CHN_NUM=5, cfg=3, en=1, mask=0)
REQ-031 Ch0 vld=1 ready=0 held from cycle 0 -> time_out[0] high only in cycle 12; tmout_sts[0]=1 from cycle 13, tmout_irq=1 from cycle 14, tmout_evt_cnt=1.
REQ-032 Ch1 stall 11 cycles, ready=1 in cycle 11, new stall from cycle 12 -> no pulse before cycle 24; pulse in cycle 24.
REQ-033 Ch2 and ch4 stall from cycle 0 -> both pulse in cycle 12, tmout_evt_cnt=2; reg_sts_clr in cycle 12 -> tmout_sts=5'b10100, tmout_evt_cnt=2.
REQ-034 Ch3 stalled with cfg=10; at cycle 20 cfg changes to 3 -> pulse in cycle 21; with mask[3]=1 instead -> no pulse, counters zero.
REQ-035 tmout_evt_cnt preloaded to 16'hFFFF via repeated expiries, one more expiry -> stays 16'hFFFF.
REQ-036 Reset pulse at cycle 8 of a ch0 stall, stall continues -> no pulse at cycle 12; pulse 12 cycles after first post-reset sampled stall.
